// File: rtl/uart_rx_cfg.sv
// Oversampled UART receiver with configurable data, parity and stop bits.
// Define UART_RX_MAJORITY_EN to take a 2-of-3 majority of the last three ticks of each bit.
module uart_rx_cfg #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clk_enb,
  input  logic                 rx,
  input  logic                 ready_clr,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic          ODD_MODE  = 1'(PARITY == 2);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  state_t                 state_q;
  logic [CW-1:0]          cnt_q;
  logic [BW-1:0]          bit_q;
  logic                   stop_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic                   perr_q;
  logic                   ferr_q;
  logic                   rx_meta_q;
  logic                   rx_sync_q;
  logic [DATA_BITS-1:0]   data_out_q;
  logic                   ready_q;
  logic                   parity_err_q;
  logic                   frame_err_q;
  logic                   overrun_q;
  logic                   bit_d;
  logic                   par_bad_d;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic maj_a_q;
  logic maj_b_q;
  logic in_bit;

  assign in_bit = (state_q == ST_DATA) || (state_q == ST_PARITY) || (state_q == ST_STOP);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      maj_a_q <= 1'b1;
      maj_b_q <= 1'b1;
    end else if (clk_enb && in_bit) begin
      if (cnt_q == CW'(OVERSAMPLE - 3)) maj_a_q <= rx_sync_q;
      if (cnt_q == CW'(OVERSAMPLE - 2)) maj_b_q <= rx_sync_q;
    end
  end

  assign bit_d = (maj_a_q & maj_b_q) | (maj_a_q & rx_sync_q) | (maj_b_q & rx_sync_q);
`else
  assign bit_d = rx_sync_q;
`endif

  // Even mode wants data^parity == 0, odd mode wants it == 1.
  assign par_bad_d = (^shift_q) ^ bit_d ^ ODD_MODE;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      stop_q       <= 1'b0;
      shift_q      <= '0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      data_out_q   <= '0;
      ready_q      <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      if (ready_clr) begin
        ready_q      <= 1'b0;
        parity_err_q <= 1'b0;
        frame_err_q  <= 1'b0;
        overrun_q    <= 1'b0;
      end
      if (clk_enb) begin
        case (state_q)
          ST_IDLE: begin
            cnt_q <= '0;
            bit_q <= '0;
            if (!rx_sync_q) state_q <= ST_START;
          end
          ST_START: begin
            if (cnt_q == CNT_HALF) begin
              cnt_q   <= '0;
              bit_q   <= '0;
              stop_q  <= 1'b0;
              perr_q  <= 1'b0;
              ferr_q  <= 1'b0;
              state_q <= rx_sync_q ? ST_IDLE : ST_DATA;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          ST_DATA: begin
            if (cnt_q == CNT_LAST) begin
              cnt_q   <= '0;
              shift_q <= {bit_d, shift_q[DATA_BITS-1:1]};
              if (bit_q == BIT_LAST) begin
                state_q <= (PARITY != 0) ? ST_PARITY : ST_STOP;
              end else begin
                bit_q <= bit_q + BW'(1);
              end
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          ST_PARITY: begin
            if (cnt_q == CNT_LAST) begin
              cnt_q   <= '0;
              perr_q  <= par_bad_d;
              state_q <= ST_STOP;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          ST_STOP: begin
            if (cnt_q == CNT_LAST) begin
              cnt_q <= '0;
              if (stop_q == STOP_LAST) begin
                // Deliver on the last stop sample; this overrides a same-edge ready_clr.
                stop_q       <= 1'b0;
                state_q      <= ST_IDLE;
                data_out_q   <= shift_q;
                ready_q      <= 1'b1;
                parity_err_q <= perr_q;
                frame_err_q  <= ferr_q | ~bit_d;
                overrun_q    <= ready_q & ~ready_clr;
              end else begin
                stop_q <= 1'b1;
                ferr_q <= ferr_q | ~bit_d;
              end
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign data_out   = data_out_q;
  assign ready      = ready_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: four parameterisations driven with tick-accurate serial frames,
// checked against a frame-level model of delivered word and status flags.
`timescale 1ns/1ps
module tb_uart_rx_cfg;
  localparam int OS = 16;
  localparam int ND = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  logic clk_enb;
  logic rx_l  [ND];
  logic clr_l [ND];
  logic [7:0] dout0, dout1, dout2;
  logic [6:0] dout3;
  logic rdy_w [ND];
  logic pe_w  [ND];
  logic fe_w  [ND];
  logic ov_w  [ND];

  int cfg_d [ND] = '{8, 8, 8, 7};
  int cfg_p [ND] = '{0, 1, 0, 2};
  int cfg_s [ND] = '{1, 1, 2, 2};

  logic [8:0] m_data [ND];
  bit m_rdy [ND];
  bit m_pe  [ND];
  bit m_fe  [ND];
  bit m_ov  [ND];

  int npass = 0;
  int ntot  = 0;

  uart_rx_cfg u0 (.clk(clk), .reset_n(reset_n), .clk_enb(clk_enb), .rx(rx_l[0]), .ready_clr(clr_l[0]),
                  .data_out(dout0), .ready(rdy_w[0]), .parity_err(pe_w[0]), .frame_err(fe_w[0]), .overrun(ov_w[0]));
  uart_rx_cfg #(.PARITY(1)) u1 (.clk(clk), .reset_n(reset_n), .clk_enb(clk_enb), .rx(rx_l[1]), .ready_clr(clr_l[1]),
                  .data_out(dout1), .ready(rdy_w[1]), .parity_err(pe_w[1]), .frame_err(fe_w[1]), .overrun(ov_w[1]));
  uart_rx_cfg #(.STOP_BITS(2)) u2 (.clk(clk), .reset_n(reset_n), .clk_enb(clk_enb), .rx(rx_l[2]), .ready_clr(clr_l[2]),
                  .data_out(dout2), .ready(rdy_w[2]), .parity_err(pe_w[2]), .frame_err(fe_w[2]), .overrun(ov_w[2]));
  uart_rx_cfg #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u3 (.clk(clk), .reset_n(reset_n), .clk_enb(clk_enb),
                  .rx(rx_l[3]), .ready_clr(clr_l[3]), .data_out(dout3), .ready(rdy_w[3]), .parity_err(pe_w[3]),
                  .frame_err(fe_w[3]), .overrun(ov_w[3]));

  function automatic logic [8:0] dout(input int d);
    case (d)
      0:       return {1'b0, dout0};
      1:       return {1'b0, dout1};
      2:       return {1'b0, dout2};
      default: return {2'b00, dout3};
    endcase
  endfunction

  task automatic tick_on();
    clk_enb = 1'b1;
    @(posedge clk); #1;
    clk_enb = 1'b0;
  endtask

  task automatic tick_gap();
    int n;
    n = $urandom_range(1, 3);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin tick_on(); tick_gap(); end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clk_enb = 1'($urandom);
    repeat (3) begin @(posedge clk); #1; end
    reset_n = 1'b1;
    clk_enb = 1'b0;
    for (int i = 0; i < ND; i++) begin
      m_data[i] = '0; m_rdy[i] = 0; m_pe[i] = 0; m_fe[i] = 0; m_ov[i] = 0;
    end
  endtask

  task automatic clear(input int d);
    clr_l[d] = 1'b1;
    @(posedge clk); #1;
    clr_l[d] = 1'b0;
    m_rdy[d] = 0; m_pe[d] = 0; m_fe[d] = 0; m_ov[d] = 0;
  endtask

  // Sends one frame on DUT d, one line bit per OS ticks; lim < total truncates the frame.
  // The receiver samples each bit at its centre, so the last stop sample lands 9 ticks
  // into the final stop bit, which is where ready must rise.
  task automatic send_frame(input int d, input logic [8:0] data, input bit bad_par, input int smask,
                            input int glitch_t, input bit clr_done, input int lim, output int rise);
    bit line[$];
    bit pb;
    int nb;
    int done_t;
    logic [8:0] dm;
    dm = data & 9'((1 << cfg_d[d]) - 1);
    line.push_back(1'b0);
    for (int i = 0; i < cfg_d[d]; i++) line.push_back(dm[i]);
    if (cfg_p[d] != 0) begin
      pb = (cfg_p[d] == 1) ? ^dm : ~^dm;
      line.push_back(pb ^ bad_par);
    end
    for (int s = 0; s < cfg_s[d]; s++) line.push_back(((smask >> s) & 1) == 0);
    nb = line.size();
    done_t = OS * (nb - 1) + OS / 2 + 1;
    rise = -1;
    for (int t = 0; t < nb * OS && t < lim; t++) begin
      rx_l[d]  = line[t / OS] ^ (t == glitch_t);
      clr_l[d] = clr_done && (t == done_t);
      tick_on();
      clr_l[d] = 1'b0;
      if (rise < 0 && rdy_w[d] === 1'b1) rise = t;
      tick_gap();
    end
    rx_l[d] = 1'b1;
    if (lim >= nb * OS) begin
      m_ov[d]   = m_rdy[d] && !clr_done;
      m_rdy[d]  = 1;
      m_data[d] = dm;
      m_pe[d]   = (cfg_p[d] != 0) && bad_par;
      m_fe[d]   = (smask & ((1 << cfg_s[d]) - 1)) != 0;
    end
  endtask

  task automatic test_reset();
    logic [12:0] got, exp;
    for (int i = 0; i < ND; i++) begin rx_l[i] = 1'b1; clr_l[i] = 1'b0; end
    do_reset();
    for (int d = 0; d < ND; d++) begin
      got = {dout(d), rdy_w[d], pe_w[d], fe_w[d], ov_w[d]};
      exp = '0;
      ntot++;
      if (got !== exp) $display("FAIL reset dut%0d got=%h required=%h", d, got, exp);
      else npass++;
    end
  endtask

  task automatic test_basic();
    int rise;
    logic [12:0] got, exp;
    send_frame(0, 9'hA5, 0, 0, -1, 0, 1 << 20, rise);
    idle(3);
    got = {dout(0), rdy_w[0], pe_w[0], fe_w[0], ov_w[0]};
    exp = {9'h0A5, 4'b1000};
    ntot++;
    if (got !== exp) $display("FAIL basic_a5 got=%h required=%h", got, exp);
    else npass++;
    ntot++;
    if (rise !== 9 * OS + 9) $display("FAIL latency got tick %0d required tick %0d", rise, 9 * OS + 9);
    else npass++;
  endtask

  task automatic test_glitch();
    int rise;
    logic [12:0] got, exp;
    clear(0);
    rx_l[0] = 1'b0;
    idle(4);
    rx_l[0] = 1'b1;
    idle(20);
    got = {dout(0), rdy_w[0], pe_w[0], fe_w[0], ov_w[0]};
    exp = {m_data[0], m_rdy[0], m_pe[0], m_fe[0], m_ov[0]};
    ntot++;
    if (got !== exp) $display("FAIL start_glitch got=%h required=%h", got, exp);
    else npass++;
    send_frame(0, 9'h3C, 0, 0, -1, 0, 1 << 20, rise);
    got = {dout(0), rdy_w[0], pe_w[0], fe_w[0], ov_w[0]};
    exp = {m_data[0], m_rdy[0], m_pe[0], m_fe[0], m_ov[0]};
    ntot++;
    if (got !== exp) $display("FAIL after_glitch_3c got=%h required=%h", got, exp);
    else npass++;
  endtask

  task automatic test_parity();
    int rise;
    int d;
    logic [12:0] got, exp;
    clear(1);
    send_frame(1, 9'h3C, 1, 0, -1, 0, 1 << 20, rise);
    got = {dout(1), rdy_w[1], pe_w[1], fe_w[1], ov_w[1]};
    exp = {9'h03C, 4'b1100};
    ntot++;
    if (got !== exp) $display("FAIL even_parity_3c got=%h required=%h", got, exp);
    else npass++;
    for (int i = 0; i < 6; i++) begin
      d = (i % 2 == 0) ? 1 : 3;
      if ($urandom_range(0, 1) == 1) clear(d);
      send_frame(d, 9'($urandom), 1'($urandom), 0, -1, 0, 1 << 20, rise);
      got = {dout(d), rdy_w[d], pe_w[d], fe_w[d], ov_w[d]};
      exp = {m_data[d], m_rdy[d], m_pe[d], m_fe[d], m_ov[d]};
      ntot++;
      if (got !== exp) $display("FAIL parity_rand dut%0d got=%h required=%h", d, got, exp);
      else npass++;
    end
  endtask

  task automatic test_stop2();
    int rise;
    logic [12:0] got, exp;
    clear(2);
    send_frame(2, 9'h81, 0, 2, -1, 0, 1 << 20, rise);
    idle(24);
    got = {dout(2), rdy_w[2], pe_w[2], fe_w[2], ov_w[2]};
    exp = {9'h081, 4'b1010};
    ntot++;
    if (got !== exp) $display("FAIL stop2_81 got=%h required=%h", got, exp);
    else npass++;
  endtask

  task automatic test_back_to_back();
    int rise;
    logic [12:0] got, exp;
    clear(0);
    send_frame(0, 9'h11, 0, 0, -1, 0, 1 << 20, rise);
    send_frame(0, 9'h22, 0, 0, -1, 0, 1 << 20, rise);
    got = {dout(0), rdy_w[0], pe_w[0], fe_w[0], ov_w[0]};
    exp = {9'h022, 4'b1001};
    ntot++;
    if (got !== exp) $display("FAIL overrun_22 got=%h required=%h", got, exp);
    else npass++;
    clear(0);
    got = {dout(0), rdy_w[0], pe_w[0], fe_w[0], ov_w[0]};
    exp = {9'h022, 4'b0000};
    ntot++;
    if (got !== exp) $display("FAIL clear_after_overrun got=%h required=%h", got, exp);
    else npass++;
    send_frame(0, 9'h44, 0, 0, -1, 0, 1 << 20, rise);
    send_frame(0, 9'h5A, 0, 0, -1, 1, 1 << 20, rise);
    got = {dout(0), rdy_w[0], pe_w[0], fe_w[0], ov_w[0]};
    exp = {9'h05A, 4'b1000};
    ntot++;
    if (got !== exp) $display("FAIL clr_same_edge got=%h required=%h", got, exp);
    else npass++;
  endtask

  task automatic test_reset_midframe();
    int rise;
    logic [12:0] got, exp;
    send_frame(0, 9'h0F, 0, 0, -1, 0, 5 * OS + 3, rise);
    do_reset();
    idle(40);
    got = {dout(0), rdy_w[0], pe_w[0], fe_w[0], ov_w[0]};
    exp = '0;
    ntot++;
    if (got !== exp) $display("FAIL reset_midframe got=%h required=%h", got, exp);
    else npass++;
    send_frame(0, 9'hC3, 0, 0, -1, 0, 1 << 20, rise);
    got = {dout(0), rdy_w[0], pe_w[0], fe_w[0], ov_w[0]};
    exp = {9'h0C3, 4'b1000};
    ntot++;
    if (got !== exp) $display("FAIL after_reset_c3 got=%h required=%h", got, exp);
    else npass++;
  endtask

  task automatic test_random();
    int rise;
    int d;
    int smask;
    logic [12:0] got, exp;
    for (int i = 0; i < 30; i++) begin
      d = $urandom_range(0, ND - 1);
      smask = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      if ($urandom_range(0, 9) < 3) clear(d);
      send_frame(d, 9'($urandom), 1'($urandom), smask, -1, 0, 1 << 20, rise);
      got = {dout(d), rdy_w[d], pe_w[d], fe_w[d], ov_w[d]};
      exp = {m_data[d], m_rdy[d], m_pe[d], m_fe[d], m_ov[d]};
      ntot++;
      if (got !== exp) $display("FAIL random_%0d dut%0d got=%h required=%h", i, d, got, exp);
      else npass++;
      idle((smask != 0) ? 24 : $urandom_range(0, 3));
    end
  endtask

  // Data bit j is sampled at count c on frame tick 9 + OS*j + c (one tick of synchronizer delay).
  task automatic test_majority();
    int rise;
    logic [8:0] exp_d;
    clear(0);
    send_frame(0, 9'h55, 0, 0, 9 + OS * 3 + (OS - 2), 0, 1 << 20, rise);
    ntot++;
    if (dout(0) !== 9'h055) $display("FAIL glitch_os_m2 got=%h required=%h", dout(0), 9'h055);
    else npass++;
    send_frame(0, 9'h55, 0, 0, 9 + OS * 3 + (OS - 3), 0, 1 << 20, rise);
    ntot++;
    if (dout(0) !== 9'h055) $display("FAIL glitch_os_m3 got=%h required=%h", dout(0), 9'h055);
    else npass++;
    send_frame(0, 9'h55, 0, 0, 9 + OS * 3 + (OS - 1), 0, 1 << 20, rise);
`ifdef UART_RX_MAJORITY_EN
    exp_d = 9'h055;
`else
    exp_d = 9'h05D;
`endif
    ntot++;
    if (dout(0) !== exp_d) $display("FAIL glitch_os_m1 got=%h required=%h", dout(0), exp_d);
    else npass++;
  endtask

  initial begin
    reset_n = 1'b0;
    clk_enb = 1'b0;
    test_reset();
    test_basic();
    test_glitch();
    test_parity();
    test_stop2();
    test_back_to_back();
    test_reset_midframe();
    test_majority();
    test_random();
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog expired after %0d of %0d checks passed", npass, ntot);
    $fatal(1);
  end

endmodule
